i2c_target_rx: RTL and testbench

//  I2C target (slave) receiver: the bus-side counterpart of our I2C master transmitter, used to

---
 rtl/i2c_pkg.sv | 19 +
 rtl/i2c_line_sync.sv | 84 ++++++++
 rtl/i2c_target_rx.sv | 189 ++++++++++++++++++
 tb/tb_i2c_target_rx.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared I2C definitions: receiver FSM states, bus bit meanings and the default address.
// Used by the target receiver and the master transmitter.
package i2c_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StAddrAck,
    StData,
    StDataAck,
    StIgnore
  } i2c_state_e;

  localparam logic       I2C_ACK          = 1'b0;
  localparam logic       I2C_NACK         = 1'b1;
  localparam logic       I2C_RW_WRITE     = 1'b0;
  localparam logic [6:0] I2C_DEFAULT_ADDR = 7'h3C;

endpackage

// File: rtl/i2c_line_sync.sv
// Input conditioning for one I2C line.
// The line passes a synchroniser chain, then an optional stability filter, and rise/fall
// pulses are derived from the cleaned value.
// Build option: I2C_RX_FILTER_EN adds the stability filter, which needs FiltLen identical
// samples before the output changes.
module i2c_line_sync #(
  parameter int unsigned SyncStages = 2,
  parameter int unsigned FiltLen    = 3
) (
  input  logic clock_i,
  input  logic reset_i,
  input  logic line_i,
  output logic line_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SyncStages-1:0] sync_q;
  logic                  synced;
  logic                  clean;
  logic                  prev_q;

  // Synchroniser chain; resets to the idle-high bus level.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SyncStages-2:0], line_i};
    end
  end

  assign synced = sync_q[SyncStages-1];

`ifdef I2C_RX_FILTER_EN
  localparam int unsigned CntW = $clog2(FiltLen + 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            filt_q, filt_d;

  // Count consecutive samples that disagree with the output; flip only after FiltLen of them.
  always_comb begin
    filt_d = filt_q;
    cnt_d  = '0;
    if (synced != filt_q) begin
      if (cnt_q == CntW'(FiltLen - 1)) begin
        filt_d = synced;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Filter state register.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      filt_q <= 1'b1;
      cnt_q  <= '0;
    end else begin
      filt_q <= filt_d;
      cnt_q  <= cnt_d;
    end
  end

  assign clean = filt_q;
`else
  logic [31:0] unused_filt_len;
  assign unused_filt_len = FiltLen;
  assign clean           = synced;
`endif

  // Previous cleaned value for edge detection.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      prev_q <= 1'b1;
    end else begin
      prev_q <= clean;
    end
  end

  assign line_o = clean;
  assign rise_o = clean & ~prev_q;
  assign fall_o = ~clean & prev_q;

endmodule

// File: rtl/i2c_target_rx.sv
// I2C target receiver.
// It oversamples scl/sda, detects START/STOP, matches a 7-bit write address and ACKs the
// address and data bytes. Each data byte is presented with a one-cycle strobe.
// Build option: I2C_RX_FILTER_EN enables spike filtering on both input lines.
module i2c_target_rx
  import i2c_pkg::*;
#(
  parameter logic [6:0]  ADDR        = I2C_DEFAULT_ADDR,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILT_LEN    = 3
) (
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe_o,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  output logic       rx_first_o,
  output logic       busy_o,
  output logic       trouble_o
);

  logic scl_s, scl_rise, scl_fall;
  logic sda_s, sda_rise, sda_fall;

  i2c_line_sync #(.SyncStages(SYNC_STAGES), .FiltLen(FILT_LEN)) u_scl_sync (
    .clock_i (clock_i),
    .reset_i (reset_i),
    .line_i  (scl_i),
    .line_o  (scl_s),
    .rise_o  (scl_rise),
    .fall_o  (scl_fall)
  );

  i2c_line_sync #(.SyncStages(SYNC_STAGES), .FiltLen(FILT_LEN)) u_sda_sync (
    .clock_i (clock_i),
    .reset_i (reset_i),
    .line_i  (sda_i),
    .line_o  (sda_s),
    .rise_o  (sda_rise),
    .fall_o  (sda_fall)
  );

  i2c_state_e state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       byte_done_q, byte_done_d;
  logic       high_q, high_d;
  logic       first_arm_q, first_arm_d;
  logic       rx_valid_q, rx_valid_d;
  logic       rx_first_q, rx_first_d;
  logic       busy_q, busy_d;
  logic       trouble_q, trouble_d;
  logic       sda_oe_q, sda_oe_d;

  logic start_det, stop_det, partial, addr_match;

  assign start_det  = sda_fall & scl_s;
  assign stop_det   = sda_rise & scl_s;
  assign addr_match = (shift_q[7:1] == ADDR) && (shift_q[0] == I2C_RW_WRITE);

  // A START/STOP rides on an scl high phase that already bumped bit_cnt, so that provisional
  // bit is not counted. A count wrapped to 0 after the 8th bit is a complete byte.
  assign partial = ((state_q == StAddr) || (state_q == StData)) &&
                   ((bit_cnt_q > 3'd1) || ((bit_cnt_q == 3'd1) && !high_q));

  // Next-state and output logic; STOP beats START beats per-state bit handling.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    rx_data_d   = rx_data_q;
    byte_done_d = byte_done_q;
    high_d      = high_q;
    first_arm_d = first_arm_q;
    rx_valid_d  = 1'b0;
    rx_first_d  = 1'b0;
    busy_d      = busy_q;
    trouble_d   = 1'b0;
    sda_oe_d    = sda_oe_q;

    if (stop_det || start_det) begin
      state_d     = stop_det ? StIdle : StAddr;
      busy_d      = ~stop_det;
      sda_oe_d    = 1'b0;
      bit_cnt_d   = '0;
      byte_done_d = 1'b0;
      high_d      = 1'b0;
      first_arm_d = 1'b0;
      trouble_d   = partial;
    end else begin
      if (((state_q == StAddr) || (state_q == StData)) && scl_rise) begin
        shift_d   = {shift_q[6:0], sda_s};
        bit_cnt_d = bit_cnt_q + 3'd1;
        high_d    = 1'b1;
        if (bit_cnt_q == 3'd7) begin
          byte_done_d = 1'b1;
        end
      end
      unique case (state_q)
        StAddr: begin
          if (scl_fall) begin
            high_d = 1'b0;
            if (byte_done_q) begin
              byte_done_d = 1'b0;
              state_d     = addr_match ? StAddrAck : StIgnore;
              sda_oe_d    = addr_match;
            end
          end
        end
        StData: begin
          if (scl_fall) begin
            high_d = 1'b0;
            if (byte_done_q) begin
              byte_done_d = 1'b0;
              state_d     = StDataAck;
              sda_oe_d    = 1'b1;
              rx_valid_d  = 1'b1;
              rx_data_d   = shift_q;
              rx_first_d  = first_arm_q;
              first_arm_d = 1'b0;
            end
          end
        end
        StAddrAck: begin
          if (scl_fall) begin
            state_d     = StData;
            sda_oe_d    = 1'b0;
            first_arm_d = 1'b1;
          end
        end
        StDataAck: begin
          if (scl_fall) begin
            state_d  = StData;
            sda_oe_d = 1'b0;
          end
        end
        StIdle, StIgnore: begin
          sda_oe_d = 1'b0;
        end
        default: begin
          state_d  = StIdle;
          sda_oe_d = 1'b0;
        end
      endcase
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q     <= StIdle;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      rx_data_q   <= '0;
      byte_done_q <= 1'b0;
      high_q      <= 1'b0;
      first_arm_q <= 1'b0;
      rx_valid_q  <= 1'b0;
      rx_first_q  <= 1'b0;
      busy_q      <= 1'b0;
      trouble_q   <= 1'b0;
      sda_oe_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      byte_done_q <= byte_done_d;
      high_q      <= high_d;
      first_arm_q <= first_arm_d;
      rx_valid_q  <= rx_valid_d;
      rx_first_q  <= rx_first_d;
      busy_q      <= busy_d;
      trouble_q   <= trouble_d;
      sda_oe_q    <= sda_oe_d;
    end
  end

  assign sda_oe_o   = sda_oe_q;
  assign rx_data_o  = rx_data_q;
  assign rx_valid_o = rx_valid_q;
  assign rx_first_o = rx_first_q;
  assign busy_o     = busy_q;
  assign trouble_o  = trouble_q;

endmodule

// File: tb/tb_i2c_target_rx.sv
// Directed bench for i2c_target_rx: a bus master model drives frames, and expected data bytes
// are queued when driven and compared when the receiver strobes them.
module tb_i2c_target_rx;
  import i2c_pkg::*;

  localparam int Q = 5;  // quarter scl period in system clocks

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_line;
  logic       sda_oe, rx_valid, rx_first, busy, trouble;
  logic [7:0] rx_data;

  // Open-drain bus: the target pulls low when sda_oe is set.
  assign sda_line = sda_m & ~sda_oe;

  always #5 clock = ~clock;

  i2c_target_rx #(.ADDR(7'h3C), .SYNC_STAGES(2), .FILT_LEN(3)) dut (
    .clock_i    (clock),
    .reset_i    (reset),
    .scl_i      (scl_m),
    .sda_i      (sda_line),
    .sda_oe_o   (sda_oe),
    .rx_data_o  (rx_data),
    .rx_valid_o (rx_valid),
    .rx_first_o (rx_first),
    .busy_o     (busy),
    .trouble_o  (trouble)
  );

  int         errors = 0;
  int         checks = 0;
  logic [8:0] sb[$];
  int         valid_cnt = 0;
  int         trouble_cnt = 0;
  bit         oe_seen = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor, sampled on the falling clock edge.
  always @(negedge clock) begin
    if (!reset) begin
      if (sda_oe) oe_seen = 1'b1;
      if (trouble) trouble_cnt++;
      if (rx_valid) begin
        logic [8:0] exp;
        valid_cnt++;
        check("valid_with_trouble", {31'd0, trouble}, 32'd0);
        check("sb_nonempty", {31'd0, sb.size() != 0}, 32'd1);
        if (sb.size() != 0) begin
          exp = sb.pop_front();
          check("rx_data", {24'd0, rx_data}, {24'd0, exp[7:0]});
          check("rx_first", {31'd0, rx_first}, {31'd0, exp[8]});
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic bus_start();
    sda_m = 1'b1; tick(Q);
    scl_m = 1'b1; tick(Q);
    sda_m = 1'b0; tick(Q);
    scl_m = 1'b0; tick(Q);
  endtask

  task automatic bus_stop();
    sda_m = 1'b0; tick(Q);
    scl_m = 1'b1; tick(Q);
    sda_m = 1'b1; tick(2 * Q);
  endtask

  task automatic bus_bit(input logic b);
    sda_m = b;    tick(Q);
    scl_m = 1'b1; tick(2 * Q);
    scl_m = 1'b0; tick(Q);
  endtask

  // Returns the sda level the master sees in the ACK slot.
  task automatic send_byte(input logic [7:0] d, output logic ack_bit);
    for (int i = 7; i >= 0; i--) bus_bit(d[i]);
    sda_m = 1'b1; tick(Q);
    scl_m = 1'b1; tick(Q);
    ack_bit = sda_line;
    tick(Q);
    scl_m = 1'b0; tick(Q);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_sda_oe"}, {31'd0, sda_oe}, 32'd0);
    check({tag, "_rx_data"}, {24'd0, rx_data}, 32'd0);
    check({tag, "_rx_valid"}, {31'd0, rx_valid}, 32'd0);
    check({tag, "_rx_first"}, {31'd0, rx_first}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_trouble"}, {31'd0, trouble}, 32'd0);
  endtask

  initial begin
    logic a;
    int   v0, t0;

    // Reset state.
    tick(4);
    check_reset_outputs("reset");
    reset = 1'b0;
    tick(10);

    // 1: good write of two bytes.
    bus_start();
    check("t1_busy_after_start", {31'd0, busy}, 32'd1);
    send_byte(8'h78, a); check("t1_addr_ack", {31'd0, a}, {31'd0, I2C_ACK});
    sb.push_back({1'b1, 8'hAE});
    send_byte(8'hAE, a); check("t1_d0_ack", {31'd0, a}, {31'd0, I2C_ACK});
    sb.push_back({1'b0, 8'hAF});
    send_byte(8'hAF, a); check("t1_d1_ack", {31'd0, a}, {31'd0, I2C_ACK});
    check("t1_busy_before_stop", {31'd0, busy}, 32'd1);
    bus_stop();
    check("t1_busy_after_stop", {31'd0, busy}, 32'd0);
    check("t1_valid_count", valid_cnt, 32'd2);
    check("t1_rx_data_held", {24'd0, rx_data}, 32'h0000_00AF);

    // 2: wrong address.
    oe_seen = 1'b0; v0 = valid_cnt;
    bus_start();
    send_byte(8'h7A, a); check("t2_addr_nack", {31'd0, a}, {31'd0, I2C_NACK});
    send_byte(8'h55, a); check("t2_data_nack", {31'd0, a}, {31'd0, I2C_NACK});
    check("t2_busy_mid", {31'd0, busy}, 32'd1);
    bus_stop();
    check("t2_busy_after_stop", {31'd0, busy}, 32'd0);
    check("t2_no_oe", {31'd0, oe_seen}, 32'd0);
    check("t2_no_valid", valid_cnt, v0);

    // 3: read of our address is NACKed and ignored.
    oe_seen = 1'b0; t0 = trouble_cnt;
    bus_start();
    send_byte(8'h79, a); check("t3_read_nack", {31'd0, a}, {31'd0, I2C_NACK});
    send_byte(8'hC3, a); check("t3_data_nack", {31'd0, a}, {31'd0, I2C_NACK});
    bus_bit(1'b0); bus_bit(1'b1);
    bus_stop();
    check("t3_no_oe", {31'd0, oe_seen}, 32'd0);
    check("t3_no_valid", valid_cnt, v0);
    check("t3_no_trouble", trouble_cnt, t0);

    // 4: STOP after three data bits, then a good frame.
    bus_start();
    send_byte(8'h78, a); check("t4_addr_ack", {31'd0, a}, {31'd0, I2C_ACK});
    bus_bit(1'b1); bus_bit(1'b0); bus_bit(1'b1);
    bus_stop();
    check("t4_trouble_once", trouble_cnt, t0 + 1);
    check("t4_no_valid", valid_cnt, v0);
    check("t4_idle", {31'd0, busy}, 32'd0);
    bus_start();
    send_byte(8'h78, a);
    sb.push_back({1'b1, 8'h5A});
    send_byte(8'h5A, a); check("t4_recover_ack", {31'd0, a}, {31'd0, I2C_ACK});
    bus_stop();
    check("t4_recover_valid", valid_cnt, v0 + 1);

    // 5: repeated START between two single-byte writes.
    v0 = valid_cnt; t0 = trouble_cnt;
    bus_start();
    send_byte(8'h78, a);
    sb.push_back({1'b1, 8'h00});
    send_byte(8'h00, a);
    bus_start();
    check("t5_busy_rs", {31'd0, busy}, 32'd1);
    send_byte(8'h78, a); check("t5_rs_addr_ack", {31'd0, a}, {31'd0, I2C_ACK});
    sb.push_back({1'b1, 8'h40});
    send_byte(8'h40, a);
    bus_stop();
    check("t5_valid_count", valid_cnt, v0 + 2);
    check("t5_no_trouble", trouble_cnt, t0);

    // 6: reset while the target drives its ACK.
    bus_start();
    for (int i = 7; i >= 0; i--) bus_bit(i[2:0] == 3'd0 ? 1'b0 : (8'h78 >> i) & 8'h01);
    sda_m = 1'b1;
    for (int i = 0; i < 40 && !sda_oe; i++) tick(1);
    check("t6_oe_before_reset", {31'd0, sda_oe}, 32'd1);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    check_reset_outputs("t6");
    reset = 1'b0;
    scl_m = 1'b1; sda_m = 1'b1;
    tick(20);
    bus_start();
    send_byte(8'h78, a); check("t6_recover_ack", {31'd0, a}, {31'd0, I2C_ACK});
    sb.push_back({1'b1, 8'h11});
    send_byte(8'h11, a);
    bus_stop();

`ifdef I2C_RX_FILTER_EN
    // One-clock sda spike while scl is high must not look like START.
    tick(10);
    sda_m = 1'b0; tick(1);
    sda_m = 1'b1; tick(20);
    check("filt_no_start", {31'd0, busy}, 32'd0);
`endif

    tick(10);
    check("sb_drained", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
